ariane_clint_slice: RTL and testbench

- Per-tile core-local interruptor slice; sits directly upstream of the Ariane tile wrapper.
- Produces the wrapper's timer interrupt (time_irq_i) and inter-processor interrupt (ipi_i) inputs for one hart.
- Holds a 64-bit mtime counter advanced by an RTC tick, a 64-bit mtimecmp register and an msip bit.
- Registers are accessed through a simple req/gnt/rvalid register port driven by the tile's config/NoC decoder.

---
 rtl/clint_pkg.sv | 26 ++
 rtl/ariane_clint_slice_sync.sv | 27 ++
 rtl/ariane_clint_slice.sv | 192 +++++++++++++++++++
 tb/tb_ariane_clint_slice.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the per-tile CLINT slice: register indices,
// reset constants and the byte-enable write merge helper.
package clint_pkg;

  // Register index decoded from addr_i[4:3].
  localparam logic [1:0] MSIP_IDX     = 2'd0;
  localparam logic [1:0] MTIMECMP_IDX = 2'd1;
  localparam logic [1:0] MTIME_IDX    = 2'd2;

  // mtimecmp resets to the maximum so the timer interrupt stays quiet
  // until software programs a real deadline.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Replace the bytes of old_val selected by be with the matching bytes of new_val.
  function automatic logic [63:0] be_merge(input logic [63:0] old_val,
                                           input logic [63:0] new_val,
                                           input logic [7:0]  be);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ariane_clint_slice_sync.sv
// Two-flop synchronizer cell for a single slow asynchronous level.
module ariane_clint_slice_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  // Resample the asynchronous input twice to settle metastability.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample their pre-edge
      // inputs; blocking here would collapse the chain into a single stage.
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/ariane_clint_slice.sv
// Core-local interruptor slice for one hart: mtime/mtimecmp/msip registers,
// RTC-driven time base and a single-cycle req/gnt/rvalid register port.
module ariane_clint_slice
  import clint_pkg::*;
#(
  parameter bit          RtcSync  = 1'b1,
  parameter logic [63:0] TimeIncr = 64'd1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rtc_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [4:0]  addr_i,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  be_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [63:0] rdata_o,
  output logic        err_o,
  output logic        time_irq_o,
  output logic        ipi_o
);

  // ---------------------------------------------------------------------------
  // RTC synchronization and edge detection
  // ---------------------------------------------------------------------------
  logic       w_rtc_s;
  logic       r_rtc_q;
  logic [2:0] r_warm;
  logic       w_armed;
  logic       w_tick;

  generate
    if (RtcSync) begin : g_rtc_sync
      ariane_clint_slice_sync u_rtc_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (rtc_i),
        .q_o    (w_rtc_s)
      );
    end else begin : g_rtc_direct
      assign w_rtc_s = rtc_i;
    end
  endgenerate

  // Edge-detect flop plus a warm-up shift that marks when the pipeline
  // holds real samples, so an rtc_i already high at reset release is not
  // mistaken for a rising edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rtc_q <= 1'b0;
      r_warm  <= 3'b000;
    end else begin
      r_rtc_q <= w_rtc_s;
      r_warm  <= {r_warm[1:0], 1'b1};
    end
  end

  // With the synchronizer, the edge flop sees a real sample only three
  // cycles after release; without it, one cycle is enough.
  assign w_armed = RtcSync ? r_warm[2] : r_warm[0];
  assign w_tick  = w_armed & w_rtc_s & ~r_rtc_q;

  // ---------------------------------------------------------------------------
  // Register port decode
  // ---------------------------------------------------------------------------
  logic [1:0] w_idx;
  logic       w_wr;
  logic       w_rd;
  logic       w_be_any;
  logic [2:0] w_unused_addr;

  assign w_idx         = addr_i[4:3];
  assign w_wr          = req_i & we_i;
  assign w_rd          = req_i & ~we_i;
  assign w_be_any      = |be_i;
  assign w_unused_addr = addr_i[2:0];

  // Every request is accepted in the cycle it is presented.
  assign gnt_o = req_i;

  // ---------------------------------------------------------------------------
  // Architectural registers
  // ---------------------------------------------------------------------------
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic        r_msip;

  logic [63:0] w_mtime_d;
  logic [63:0] w_mtimecmp_d;
  logic        w_msip_d;

  // Next-state selection: a software write to mtime overrides the tick for
  // the whole cycle, so the increment is never blended into unwritten bytes.
  always_comb begin
    // NOTE: every signal gets a default before any condition so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_mtime_d    = r_mtime;
    w_mtimecmp_d = r_mtimecmp;
    w_msip_d     = r_msip;

    if (w_wr && (w_idx == MTIME_IDX) && w_be_any) begin
      w_mtime_d = be_merge(r_mtime, wdata_i, be_i);
    end else if (w_tick) begin
      w_mtime_d = r_mtime + TimeIncr;
    end

    if (w_wr && (w_idx == MTIMECMP_IDX)) begin
      w_mtimecmp_d = be_merge(r_mtimecmp, wdata_i, be_i);
    end

    if (w_wr && (w_idx == MSIP_IDX) && be_i[0]) begin
      w_msip_d = wdata_i[0];
    end
  end

  // Register update; all three reset to their architectural values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mtime    <= 64'd0;
      r_mtimecmp <= MTIMECMP_RST;
      r_msip     <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_d;
      r_mtimecmp <= w_mtimecmp_d;
      r_msip     <= w_msip_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response path
  // ---------------------------------------------------------------------------
  logic [63:0] w_rdata;
  logic        w_err;

  // Read mux over the pre-update register values of the grant cycle.
  always_comb begin
    w_rdata = 64'd0;
    w_err   = req_i & (w_idx == 2'd3);
    if (w_rd) begin
      unique case (w_idx)
        MSIP_IDX:     w_rdata = {63'd0, r_msip};
        MTIMECMP_IDX: w_rdata = r_mtimecmp;
        MTIME_IDX:    w_rdata = r_mtime;
        default:      w_rdata = 64'd0;
      endcase
    end
  end

  logic        r_rvalid;
  logic [63:0] r_rdata;
  logic        r_err;

  // One-cycle response for every accepted request, reads and writes alike.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 64'd0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= req_i;
      r_rdata  <= w_rdata;
      r_err    <= w_err;
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err;

  // ---------------------------------------------------------------------------
  // Interrupt outputs
  // ---------------------------------------------------------------------------
  logic r_time_irq;
  logic r_ipi;

  // Interrupt levels sampled from the settled registers, one cycle behind them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_time_irq <= 1'b0;
      r_ipi      <= 1'b0;
    end else begin
      r_time_irq <= (r_mtime >= r_mtimecmp);
      r_ipi      <= r_msip;
    end
  end

  assign time_irq_o = r_time_irq;
  assign ipi_o      = r_ipi;

endmodule

// File: tb/tb_ariane_clint_slice.sv
// Directed self-checking bench for ariane_clint_slice (RtcSync = 1, TimeIncr = 1).
module tb_ariane_clint_slice;

  logic        clk_i;
  logic        rst_ni;
  logic        rtc_i;
  logic        req_i;
  logic        we_i;
  logic [4:0]  addr_i;
  logic [63:0] wdata_i;
  logic [7:0]  be_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [63:0] rdata_o;
  logic        err_o;
  logic        time_irq_o;
  logic        ipi_o;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] A_MSIP     = 5'h00;
  localparam logic [4:0] A_MTIMECMP = 5'h08;
  localparam logic [4:0] A_MTIME    = 5'h10;
  localparam logic [4:0] A_INVALID  = 5'h18;

  ariane_clint_slice #(
    .RtcSync  (1'b1),
    .TimeIncr (64'd1)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rtc_i      (rtc_i),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .be_i       (be_i),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .time_irq_o (time_irq_o),
    .ipi_o      (ipi_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic rd(input logic [4:0] a, input logic [63:0] exp_d,
                    input logic exp_e, input string tag);
    req_i = 1'b1; we_i = 1'b0; addr_i = a; be_i = 8'h00; wdata_i = 64'd0;
    #1 check({tag, ".gnt"}, 64'(gnt_o), 64'd1);
    cyc();
    req_i = 1'b0;
    check({tag, ".rvalid"}, 64'(rvalid_o), 64'd1);
    check({tag, ".rdata"}, rdata_o, exp_d);
    check({tag, ".err"}, 64'(err_o), 64'(exp_e));
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d,
                    input logic [7:0] be, input string tag);
    req_i = 1'b1; we_i = 1'b1; addr_i = a; be_i = be; wdata_i = d;
    cyc();
    req_i = 1'b0; we_i = 1'b0;
    check({tag, ".rvalid"}, 64'(rvalid_o), 64'd1);
    check({tag, ".err"}, 64'(err_o), 64'd0);
  endtask

  initial begin
    rst_ni = 1'b0; rtc_i = 1'b1; req_i = 1'b0; we_i = 1'b0;
    addr_i = 5'd0; wdata_i = 64'd0; be_i = 8'd0;

    // Reset values, with rtc_i high throughout reset.
    #12;
    check("rst.rvalid", 64'(rvalid_o), 64'd0);
    check("rst.rdata", rdata_o, 64'd0);
    check("rst.err", 64'(err_o), 64'd0);
    check("rst.irq", 64'(time_irq_o), 64'd0);
    check("rst.ipi", 64'(ipi_o), 64'd0);
    check("rst.gnt", 64'(gnt_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // rtc_i high at release: no spurious tick over 10 cycles.
    cyc(10);
    rd(A_MTIME, 64'd0, 1'b0, "norst_tick");
    check("norst.irq", 64'(time_irq_o), 64'd0);
    check("norst.ipi", 64'(ipi_o), 64'd0);
    rd(A_MTIMECMP, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "cmp_rst");

    // MSIP set and clear.
    wr(A_MSIP, 64'd1, 8'h01, "msip_set");
    cyc();
    check("msip_set.ipi", 64'(ipi_o), 64'd1);
    rd(A_MSIP, 64'd1, 1'b0, "msip_rd");
    wr(A_MSIP, 64'd0, 8'h01, "msip_clr");
    cyc();
    check("msip_clr.ipi", 64'(ipi_o), 64'd0);

    // Timer compare with synchronized RTC edges.
    rtc_i = 1'b0;
    cyc(4);
    wr(A_MTIMECMP, 64'd5, 8'hFF, "cmp5");
    for (int i = 0; i < 4; i++) begin
      rtc_i = 1'b1; cyc(4);
      rtc_i = 1'b0; cyc(4);
    end
    rd(A_MTIME, 64'd4, 1'b0, "mtime4");
    check("mtime4.irq", 64'(time_irq_o), 64'd0);
    rtc_i = 1'b1;
    cyc(3);
    check("mtime5.irq_pre", 64'(time_irq_o), 64'd0);
    rd(A_MTIME, 64'd5, 1'b0, "mtime5");
    check("mtime5.irq", 64'(time_irq_o), 64'd1);
    rtc_i = 1'b0;
    cyc(4);
    wr(A_MTIMECMP, 64'd100, 8'hFF, "cmp100");
    check("cmp100.irq_hold", 64'(time_irq_o), 64'd1);
    cyc();
    check("cmp100.irq_clr", 64'(time_irq_o), 64'd0);

    // 64-bit wrap-around of mtime.
    wr(A_MTIMECMP, 64'd10, 8'hFF, "cmp10");
    wr(A_MTIME, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, "mtime_max");
    cyc();
    check("wrap.irq_pre", 64'(time_irq_o), 64'd1);
    rtc_i = 1'b1;
    cyc(3);
    check("wrap.irq_lag", 64'(time_irq_o), 64'd1);
    cyc();
    check("wrap.irq_post", 64'(time_irq_o), 64'd0);
    rd(A_MTIME, 64'd0, 1'b0, "wrap_rd");
    rtc_i = 1'b0;
    cyc(4);

    // Partial MTIME write colliding with a detected tick: tick dropped.
    wr(A_MTIME, 64'h0000_0001_0000_0010, 8'hFF, "mtime_pre");
    rtc_i = 1'b1;
    cyc(2);
    wr(A_MTIME, 64'h0000_0000_0000_0003, 8'h0F, "mtime_coll");
    rd(A_MTIME, 64'h0000_0001_0000_0003, 1'b0, "coll_rd");
    rtc_i = 1'b0;
    cyc(4);

    // Back-to-back reads: invalid address then MTIME.
    req_i = 1'b1; we_i = 1'b0; addr_i = A_INVALID; be_i = 8'h00;
    cyc();
    check("b2b0.rvalid", 64'(rvalid_o), 64'd1);
    check("b2b0.rdata", rdata_o, 64'd0);
    check("b2b0.err", 64'(err_o), 64'd1);
    addr_i = A_MTIME;
    cyc();
    req_i = 1'b0;
    check("b2b1.rvalid", 64'(rvalid_o), 64'd1);
    check("b2b1.rdata", rdata_o, 64'h0000_0001_0000_0003);
    check("b2b1.err", 64'(err_o), 64'd0);
    cyc();
    check("b2b.idle_rvalid", 64'(rvalid_o), 64'd0);
    check("b2b.irq", 64'(time_irq_o), 64'd1);

    // Write to invalid address reports an error and changes nothing.
    req_i = 1'b1; we_i = 1'b1; addr_i = A_INVALID; be_i = 8'hFF; wdata_i = 64'd0;
    cyc();
    req_i = 1'b0; we_i = 1'b0;
    check("inv_wr.err", 64'(err_o), 64'd1);
    rd(A_MTIME, 64'h0000_0001_0000_0003, 1'b0, "inv_wr_mtime");

    // Reset pulse between grant and rvalid drops the response.
    req_i = 1'b1; we_i = 1'b0; addr_i = A_MTIME;
    #2 rst_ni = 1'b0;
    #1 check("rstmid.rvalid_now", 64'(rvalid_o), 64'd0);
    cyc();
    check("rstmid.rvalid", 64'(rvalid_o), 64'd0);
    check("rstmid.irq", 64'(time_irq_o), 64'd0);
    req_i = 1'b0;
    rst_ni = 1'b1;
    cyc(4);
    rd(A_MTIME, 64'd0, 1'b0, "rstmid_mtime");
    rd(A_MTIMECMP, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "rstmid_cmp");
    check("rstmid.ipi", 64'(ipi_o), 64'd0);

    // First genuine RTC edge after reset is counted.
    rtc_i = 1'b1;
    cyc(4);
    rd(A_MTIME, 64'd1, 1'b0, "post_rst_tick");
    rtc_i = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
